// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier, one Booth step per clock, signed/unsigned per operation.
// Latency RW+1 cycles from the accept edge to the done pulse; product is registered.
// start is ignored while busy; start during done is accepted back-to-back.
module seq_booth_multiplier #(
    parameter int MW = 8,
    parameter int RW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [MW-1:0]    m,
    input  logic [RW-1:0]    r,
    output logic             busy,
    output logic             done,
    output logic [MW+RW-1:0] product
);

    localparam int PW = MW + RW + 4;
    localparam int CW = $clog2(RW + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   p;
    logic [MW+1:0]   m_pos;
    logic [MW+1:0]   m_neg;
    logic [CW-1:0]   cnt;

    logic            m_sx;
    logic            r_sx;
    logic [MW+1:0]   upper;
    logic [MW+1:0]   upper_sum;
    logic [PW-1:0]   p_step;

    assign m_sx = signed_mode & m[MW-1];
    assign r_sx = signed_mode & r[RW-1];

    // One Booth step: conditional add/subtract on the upper field, then arithmetic shift.
    always_comb begin
        upper     = p[PW-1 -: MW+2];
        upper_sum = upper;
        case (p[1:0])
            2'b01:   upper_sum = upper + m_pos;
            2'b10:   upper_sum = upper + m_neg;
            default: upper_sum = upper;
        endcase
        p_step = {upper_sum[MW+1], upper_sum, p[RW+1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            p       <= '0;
            m_pos   <= '0;
            m_neg   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Multiplicand kept at MW+2 bits so negating the most negative value fits.
                        p     <= {{(MW+2){1'b0}}, r_sx, r, 1'b0};
                        m_pos <= {{2{m_sx}}, m};
                        m_neg <= -{{2{m_sx}}, m};
                        cnt   <= CW'(RW + 1);
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p   <= p_step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        product <= p_step[MW+RW:1];
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Bench for seq_booth_multiplier: directed table, multi-cycle corner sequences and a
// randomized sweep at 8x8 and 5x11 against an arithmetic reference model.
module tb_seq_booth_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, sm8;
    logic [7:0]  m8, r8;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start5, sm5;
    logic [4:0]  m5;
    logic [10:0] r5;
    logic        busy5, done5;
    logic [15:0] prod5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_booth_multiplier #(.MW(8), .RW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .m(m8), .r(r8), .busy(busy8), .done(done8), .product(prod8)
    );

    seq_booth_multiplier #(.MW(5), .RW(11)) dut511 (
        .clk(clk), .rst_n(rst_n), .start(start5), .signed_mode(sm5),
        .m(m5), .r(r5), .busy(busy5), .done(done5), .product(prod5)
    );

    typedef struct {
        bit          sm;
        logic [7:0]  m;
        logic [7:0]  r;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact integer product truncated to mw+rw bits.
    function automatic logic [63:0] ref_mul(input int mw, input int rw, input bit sm,
                                            input logic [63:0] a, input logic [63:0] b);
        longint sa, sb, pr;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[mw-1]) sa = sa - (longint'(1) << mw);
        if (sm && b[rw-1]) sb = sb - (longint'(1) << rw);
        pr = sa * sb;
        return 64'(pr) & ((64'd1 << (mw + rw)) - 64'd1);
    endfunction

    task automatic op8(input bit sm, input logic [7:0] mm, input logic [7:0] rr,
                       input logic [15:0] exp, input string name);
        int j;
        int nb;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; m8 = mm; r8 = rr;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; sm8 = 1'($urandom); m8 = 8'($urandom); r8 = 8'($urandom);
        nb = 0;
        for (j = 0; j < 30; j++) begin
            if (done8) break;
            if (busy8) nb++;
            @(negedge clk);
        end
        check({name, " done latency"}, 64'(j), 64'd9);
        check({name, " busy cycles"}, 64'(nb), 64'd9);
        check({name, " product"}, 64'(prod8), 64'(exp));
        @(negedge clk);
        check({name, " done width"}, 64'(done8), 64'd0);
    endtask

    task automatic op511(input bit sm, input logic [4:0] mm, input logic [10:0] rr,
                         input logic [15:0] exp, input string name);
        int j;
        @(negedge clk);
        start5 = 1'b1; sm5 = sm; m5 = mm; r5 = rr;
        @(posedge clk);
        @(negedge clk);
        start5 = 1'b0; m5 = 5'($urandom); r5 = 11'($urandom);
        for (j = 0; j < 40; j++) begin
            if (done5) break;
            @(negedge clk);
        end
        check({name, " done latency"}, 64'(j), 64'd12);
        check({name, " product"}, 64'(prod5), 64'(exp));
    endtask

    initial begin
        int nd, dj, nb, cyc;
        logic [15:0] pr;
        logic [7:0]  sm_ops[3];
        logic [7:0]  m_ops[3];
        logic [7:0]  r_ops[3];
        logic [15:0] p_ops[3];

        tbl[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        tbl[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[3] = '{1'b0, 8'h80, 8'h02, 16'h0100};
        tbl[4] = '{1'b1, 8'h80, 8'h02, 16'hFF00};
        tbl[5] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        tbl[6] = '{1'b0, 8'h00, 8'hFF, 16'h0000};
        tbl[7] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tbl[8] = '{1'b0, 8'h01, 8'hFF, 16'h00FF};
        tbl[9] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};

        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; r8 = '0;
        start5 = 1'b0; sm5 = 1'b0; m5 = '0; r5 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy8), 64'd0);
        check("reset done", 64'(done8), 64'd0);
        check("reset product", 64'(prod8), 64'd0);
        check("reset product 5x11", 64'(prod5), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            op8(tbl[i].sm, tbl[i].m, tbl[i].r, tbl[i].p, $sformatf("vec%0d", i));

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; m8 = 8'd3; r8 = 8'd4;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        nd = 0; dj = -1; pr = '0;
        for (int j = 0; j < 25; j++) begin
            if (j == 3) begin start8 = 1'b1; m8 = 8'h7F; r8 = 8'h7F; end
            if (j == 4) start8 = 1'b0;
            if (done8) begin nd++; dj = j; pr = prod8; end
            @(negedge clk);
        end
        check("busy-start done count", 64'(nd), 64'd1);
        check("busy-start done time", 64'(dj), 64'd9);
        check("busy-start product", 64'(pr), 64'h000C);

        // reset mid-RUN aborts with no done
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; m8 = 8'd5; r8 = 8'd5;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        check("abort product", 64'(prod8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0; nb = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (done8) nd++;
            if (busy8) nb++;
        end
        check("abort no done", 64'(nd), 64'd0);
        check("abort no busy", 64'(nb), 64'd0);

        // start held high: back-to-back operations every RW+2 cycles
        m_ops = '{8'd7, 8'hFF, 8'h00};
        r_ops = '{8'd6, 8'hFF, 8'h7F};
        p_ops = '{16'h002A, 16'h0001, 16'h0000};
        sm_ops = '{8'd1, 8'd1, 8'd1};
        @(negedge clk);
        start8 = 1'b1; sm8 = sm_ops[0][0]; m8 = m_ops[0]; r8 = r_ops[0];
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done8 && cyc < 30);
            check($sformatf("b2b op%0d gap", i), 64'(cyc), (i == 0) ? 64'd9 : 64'd10);
            check($sformatf("b2b op%0d product", i), 64'(prod8), 64'(p_ops[i]));
            if (i < 2) begin
                sm8 = sm_ops[i+1][0]; m8 = m_ops[i+1]; r8 = r_ops[i+1];
            end else begin
                start8 = 1'b0;
            end
        end
        @(negedge clk);

        fork
            begin
                bit          s;
                logic [7:0]  a, b;
                for (int i = 0; i < 3000; i++) begin
                    s = 1'($urandom);
                    a = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                    op8(s, a, b, 16'(ref_mul(8, 8, s, 64'(a), 64'(b))), "rand8x8");
                end
            end
            begin
                bit          s;
                logic [4:0]  a;
                logic [10:0] b;
                for (int i = 0; i < 3000; i++) begin
                    s = 1'($urandom);
                    a = ($urandom_range(0, 7) == 0) ? 5'h10 : 5'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? 11'h400 : 11'($urandom);
                    op511(s, a, b, 16'(ref_mul(5, 11, s, 64'(a), 64'(b))), "rand5x11");
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
